// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, instruction
// classes, ALU operation codes, opcode/func constants and datapath mux selects.
package mc_pkg;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

    typedef enum logic [3:0] {
        C_RALU, C_SHIFT, C_JR, C_JALR, C_IALU,
        C_LOAD, C_STORE, C_BRANCH, C_J, C_ILL
    } cls_t;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_BGEZ = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_BGTZ = 5'b00011;
    localparam logic [4:0] ALU_SLTU = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_AND  = 5'b00110;
    localparam logic [4:0] ALU_NOR  = 5'b00111;
    localparam logic [4:0] ALU_OR   = 5'b01000;
    localparam logic [4:0] ALU_XOR  = 5'b01001;
    localparam logic [4:0] ALU_SLL  = 5'b01010;
    localparam logic [4:0] ALU_LUI  = 5'b01011;
    localparam logic [4:0] ALU_SRA  = 5'b01100;
    localparam logic [4:0] ALU_BLEZ = 5'b01101;
    localparam logic [4:0] ALU_SRL  = 5'b01110;
    localparam logic [4:0] ALU_BLTZ = 5'b01111;
    localparam logic [4:0] ALU_BNE  = 5'b11111;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_RS  = 2'd3;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps op/func/rt to an instruction class
// plus the ALU operation, operand source, immediate extension and shift source.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] rt,
    output cls_t       cls,
    output logic [4:0] alu_op,
    output logic       alu_src,
    output logic       ext_op,
    output logic       shf_op
);

    always_comb begin
        cls     = C_ILL;
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        ext_op  = 1'b1;
        shf_op  = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls = C_RALU;
                case (func)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:  begin cls = C_SHIFT; alu_op = ALU_SLL; shf_op = 1'b1; end
                    FN_SRL:  begin cls = C_SHIFT; alu_op = ALU_SRL; shf_op = 1'b1; end
                    FN_SRA:  begin cls = C_SHIFT; alu_op = ALU_SRA; shf_op = 1'b1; end
                    FN_SLLV: begin cls = C_SHIFT; alu_op = ALU_SLL; end
                    FN_SRLV: begin cls = C_SHIFT; alu_op = ALU_SRL; end
                    FN_SRAV: begin cls = C_SHIFT; alu_op = ALU_SRA; end
                    FN_JR:           cls = C_JR;
                    FN_JALR:         cls = C_JALR;
                    default:         cls = C_ILL;
                endcase
            end
            // Every REGIMM rt other than bgez is treated as bltz
            OP_REGIMM: begin
                cls    = C_BRANCH;
                alu_op = (rt == RT_BGEZ) ? ALU_BGEZ : ALU_BLTZ;
            end
            OP_J:    cls = C_J;
            OP_BEQ:  begin cls = C_BRANCH; alu_op = ALU_SUB;  end
            OP_BNE:  begin cls = C_BRANCH; alu_op = ALU_BNE;  end
            OP_BLEZ: begin cls = C_BRANCH; alu_op = ALU_BLEZ; end
            OP_BGTZ: begin cls = C_BRANCH; alu_op = ALU_BGTZ; end
            OP_ADDI, OP_ADDIU: begin cls = C_IALU; alu_op = ALU_ADD;  alu_src = 1'b1; end
            OP_SLTI:           begin cls = C_IALU; alu_op = ALU_SLT;  alu_src = 1'b1; end
            OP_SLTIU:          begin cls = C_IALU; alu_op = ALU_SLTU; alu_src = 1'b1; end
            OP_ANDI: begin cls = C_IALU; alu_op = ALU_AND; alu_src = 1'b1; ext_op = 1'b0; end
            OP_ORI:  begin cls = C_IALU; alu_op = ALU_OR;  alu_src = 1'b1; ext_op = 1'b0; end
            OP_XORI: begin cls = C_IALU; alu_op = ALU_XOR; alu_src = 1'b1; ext_op = 1'b0; end
            OP_LUI:  begin cls = C_IALU; alu_op = ALU_LUI; alu_src = 1'b1; ext_op = 1'b0; end
            OP_LB, OP_LBU, OP_LW: begin cls = C_LOAD;  alu_src = 1'b1; end
            OP_SB, OP_SW:         begin cls = C_STORE; alu_src = 1'b1; end
            default: cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the shared MIPS datapath, with req/ready memory
// handshakes bounded by a wait-state timeout that raises bus_err.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] rt,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic       ext_op,
    output logic [4:0] alu_op,
    output logic       shf_op,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       dm_op,
    output logic       bit_op,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       illegal,
    output logic       bus_err
);

    state_t          state_reg, state_next;
    cls_t            cls_reg, cls_dec;
    logic [TO_W-1:0] to_cnt_reg;
    logic [4:0]      dec_alu_op;
    logic            dec_alu_src, dec_ext_op, dec_shf_op;
    logic            mem_ready, waiting, timeout;

    mc_decode u_decode (
        .op      (op),
        .func    (func),
        .rt      (rt),
        .cls     (cls_dec),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .ext_op  (dec_ext_op),
        .shf_op  (dec_shf_op)
    );

    assign mem_ready = (state_reg == S_IF) ? imem_ready : dmem_ready;
    assign waiting   = ((state_reg == S_IF) || (state_reg == S_MEM)) && !mem_ready;
    assign timeout   = waiting && (to_cnt_reg == TO_W'(MEM_TIMEOUT));

    // A timeout in S_IF re-enters S_IF, so the counter clears on timeout as well
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IF;
            cls_reg    <= C_RALU;
            to_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            if (state_reg == S_ID)
                cls_reg <= cls_dec;
            to_cnt_reg <= (waiting && !timeout) ? to_cnt_reg + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = PC_SEQ;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        alu_op     = ALU_ADD;
        shf_op     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dm_op      = 1'b0;
        bit_op     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = M2R_ALU;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_IF: begin
                    imem_req = 1'b1;
                    ir_wr    = 1'b1;
                    if (imem_ready) begin
                        pc_wr      = 1'b1;
                        state_next = S_ID;
                    end else if (timeout) begin
                        bus_err    = 1'b1;
                        state_next = S_IF;
                    end
                end
                S_ID: begin
                    case (cls_dec)
                        C_J:    begin pc_wr = 1'b1; pc_src = PC_JMP; state_next = S_IF; end
                        C_JR:   begin pc_wr = 1'b1; pc_src = PC_RS;  state_next = S_IF; end
                        C_JALR: begin pc_wr = 1'b1; pc_src = PC_RS;  state_next = S_WB; end
                        C_ILL:  begin illegal = 1'b1; state_next = S_IF; end
                        default: state_next = S_EX;
                    endcase
                end
                S_EX: begin
                    alu_op  = dec_alu_op;
                    alu_src = dec_alu_src;
                    ext_op  = dec_ext_op;
                    shf_op  = dec_shf_op;
                    if (cls_reg == C_BRANCH) begin
                        pc_wr      = zero;
                        pc_src     = PC_BR;
                        state_next = S_IF;
                    end else if ((cls_reg == C_LOAD) || (cls_reg == C_STORE)) begin
                        state_next = S_MEM;
                    end else begin
                        state_next = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls_reg == C_STORE) && !timeout;
                    dm_op    = (op == OP_LW) || (op == OP_SW);
                    bit_op   = (op == OP_LB);
                    if (dmem_ready) begin
                        state_next = (cls_reg == C_LOAD) ? S_WB : S_IF;
                    end else if (timeout) begin
                        bus_err    = 1'b1;
                        state_next = S_IF;
                    end
                end
                S_WB: begin
                    reg_wr     = 1'b1;
                    reg_dst    = ((cls_reg == C_RALU) || (cls_reg == C_SHIFT) ||
                                  (cls_reg == C_JALR)) ? 2'd1 : 2'd0;
                    mem_to_reg = (cls_reg == C_LOAD) ? M2R_MEM :
                                 (cls_reg == C_JALR) ? M2R_PC4 : M2R_ALU;
                    state_next = S_IF;
                end
                default: state_next = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks instruction classes cycle by cycle and
// compares the control outputs against hand-derived expectations.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, func = '0;
    logic [4:0] rt = '0;
    logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, ir_wr, pc_wr, alu_src, ext_op, shf_op;
    logic       dmem_req, dmem_we, dm_op, bit_op, reg_wr, illegal, bus_err;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic [4:0] alu_op;
    logic [23:0] outs;

    int errors = 0;
    int checks = 0;

    // Immediate/shift table: xori, sra, slti, srlv, lui, nor
    logic [5:0] ia_op  [6] = '{6'b001110, 6'b000000, 6'b001010, 6'b000000, 6'b001111, 6'b000000};
    logic [5:0] ia_fn  [6] = '{6'b000000, 6'b000011, 6'b000000, 6'b000110, 6'b000000, 6'b100111};
    logic [4:0] ia_alu [6] = '{5'b01001, 5'b01100, 5'b00101, 5'b01110, 5'b01011, 5'b00111};
    logic       ia_src [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       ia_ext [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       ia_shf [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] ia_dst [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};

    // Branch table: beq taken, beq not taken, bne, bgez, bltz, bgtz
    logic [5:0] br_op  [6] = '{6'b000100, 6'b000100, 6'b000101, 6'b000001, 6'b000001, 6'b000111};
    logic [4:0] br_rt  [6] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0};
    logic       br_z   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] br_alu [6] = '{5'b00010, 5'b00010, 5'b11111, 5'b00001, 5'b01111, 5'b00011};

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .rt(rt), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
        .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .shf_op(shf_op),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dm_op(dm_op), .bit_op(bit_op),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .bus_err(bus_err)
    );

    assign outs = {imem_req, ir_wr, pc_wr, pc_src, alu_src, ext_op, alu_op, shf_op,
                   dmem_req, dmem_we, dm_op, bit_op, reg_wr, reg_dst, mem_to_reg,
                   illegal, bus_err};

    always #5 clk = ~clk;

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Fetch (imem_ready=1) and decode an instruction, leaving the FSM entering S_EX/next state
    task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
        op = o; func = f; rt = r; imem_ready = 1'b1; dmem_ready = 1'b0;
        #1; nxt; #1; nxt;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            op = 6'($urandom); func = 6'($urandom); rt = 5'($urandom);
            zero = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            #1;
            checks++; if (outs !== 24'd0) begin errors++; $display("FAIL reset_outs got=%h exp=000000", outs); end
            nxt;
        end
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_imem_req got=%0b exp=1", imem_req); end
        checks++; if (pc_wr !== 1'b0) begin errors++; $display("FAIL reset_pc_wr got=%0b exp=0", pc_wr); end
        $display("txn reset: released, fetching");
    endtask

    task automatic test_addu;
        op = 6'b000000; func = 6'b100001; rt = 5'd0; imem_ready = 1'b1;
        #1;
        checks++; if (pc_wr !== 1'b1 || pc_src !== 2'd0 || ir_wr !== 1'b1) begin errors++; $display("FAIL addu_c1 got pc_wr=%0b pc_src=%0d ir_wr=%0b exp 1/0/1", pc_wr, pc_src, ir_wr); end
        nxt; #1;
        checks++; if (pc_wr !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL addu_c2 got pc_wr=%0b imem_req=%0b exp 0/0", pc_wr, imem_req); end
        nxt; #1;
        checks++; if (alu_op !== 5'b00000 || alu_src !== 1'b0 || reg_wr !== 1'b0) begin errors++; $display("FAIL addu_c3 got alu_op=%b alu_src=%0b reg_wr=%0b exp 00000/0/0", alu_op, alu_src, reg_wr); end
        nxt; #1;
        checks++; if (reg_wr !== 1'b1 || reg_dst !== 2'd1 || mem_to_reg !== 2'd0) begin errors++; $display("FAIL addu_c4 got reg_wr=%0b reg_dst=%0d m2r=%0d exp 1/1/0", reg_wr, reg_dst, mem_to_reg); end
        nxt; #1;
        checks++; if (imem_req !== 1'b1 || reg_wr !== 1'b0) begin errors++; $display("FAIL addu_c5 got imem_req=%0b reg_wr=%0b exp 1/0", imem_req, reg_wr); end
        $display("txn addu: 4-cycle sequence");
    endtask

    task automatic test_alu_table;
        for (int i = 0; i < 6; i++) begin
            fetch_decode(ia_op[i], ia_fn[i], 5'd0);
            #1;
            checks++; if (alu_op !== ia_alu[i] || alu_src !== ia_src[i] || ext_op !== ia_ext[i] || shf_op !== ia_shf[i])
                begin errors++; $display("FAIL alu_ex[%0d] got op=%b src=%0b ext=%0b shf=%0b exp op=%b src=%0b ext=%0b shf=%0b", i, alu_op, alu_src, ext_op, shf_op, ia_alu[i], ia_src[i], ia_ext[i], ia_shf[i]); end
            nxt; #1;
            checks++; if (reg_wr !== 1'b1 || reg_dst !== ia_dst[i] || mem_to_reg !== 2'd0)
                begin errors++; $display("FAIL alu_wb[%0d] got reg_wr=%0b reg_dst=%0d m2r=%0d exp 1/%0d/0", i, reg_wr, reg_dst, mem_to_reg, ia_dst[i]); end
            nxt;
            $display("txn alu[%0d]: op=%b func=%b", i, ia_op[i], ia_fn[i]);
        end
    endtask

    task automatic test_load;
        fetch_decode(6'b100011, 6'd0, 5'd0);
        #1;
        checks++; if (alu_src !== 1'b1 || ext_op !== 1'b1 || alu_op !== 5'b00000) begin errors++; $display("FAIL lw_ex got src=%0b ext=%0b op=%b exp 1/1/00000", alu_src, ext_op, alu_op); end
        nxt;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = 1'b0; #1;
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dm_op !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL lw_wait[%0d] got req=%0b we=%0b dm_op=%0b bus_err=%0b exp 1/0/1/0", i, dmem_req, dmem_we, dm_op, bus_err); end
            nxt;
        end
        dmem_ready = 1'b1; #1;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || reg_wr !== 1'b0) begin errors++; $display("FAIL lw_ready got req=%0b we=%0b reg_wr=%0b exp 1/0/0", dmem_req, dmem_we, reg_wr); end
        nxt; dmem_ready = 1'b0; #1;
        checks++; if (reg_wr !== 1'b1 || mem_to_reg !== 2'd1 || reg_dst !== 2'd0 || dmem_we !== 1'b0) begin errors++; $display("FAIL lw_wb got reg_wr=%0b m2r=%0d reg_dst=%0d we=%0b exp 1/1/0/0", reg_wr, mem_to_reg, reg_dst, dmem_we); end
        nxt; #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lw_ret got imem_req=%0b exp 1", imem_req); end
        $display("txn lw: 3 wait states");
        // lb: byte access, sign-extended
        fetch_decode(6'b100000, 6'd0, 5'd0);
        nxt; dmem_ready = 1'b1; #1;
        checks++; if (bit_op !== 1'b1 || dm_op !== 1'b0) begin errors++; $display("FAIL lb_mem got bit_op=%0b dm_op=%0b exp 1/0", bit_op, dm_op); end
        nxt; dmem_ready = 1'b0; nxt;
        $display("txn lb: zero wait states");
    endtask

    task automatic test_branch;
        for (int i = 0; i < 6; i++) begin
            op = br_op[i]; rt = br_rt[i]; func = 6'd0; imem_ready = 1'b1; zero = br_z[i];
            #1; nxt; #1;
            checks++; if (pc_wr !== 1'b0) begin errors++; $display("FAIL br_id[%0d] got pc_wr=%0b exp 0", i, pc_wr); end
            nxt; #1;
            checks++; if (pc_wr !== br_z[i] || pc_src !== 2'd1 || alu_op !== br_alu[i] || reg_wr !== 1'b0)
                begin errors++; $display("FAIL br_ex[%0d] got pc_wr=%0b pc_src=%0d alu=%b reg_wr=%0b exp %0b/1/%b/0", i, pc_wr, pc_src, alu_op, reg_wr, br_z[i], br_alu[i]); end
            nxt; #1;
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL br_ret[%0d] got imem_req=%0b exp 1", i, imem_req); end
            $display("txn branch[%0d]: op=%b zero=%0b", i, br_op[i], br_z[i]);
        end
        zero = 1'b0;
    endtask

    task automatic test_timeout;
        int seen_wr;
        // Store with no data response: 15 wait cycles, bus_err on the 16th
        fetch_decode(6'b101011, 6'd0, 5'd0);
        nxt; dmem_ready = 1'b0; seen_wr = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (reg_wr) seen_wr++;
            checks++; if (bus_err !== 1'b0 || dmem_we !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL sw_wait[%0d] got bus_err=%0b we=%0b req=%0b exp 0/1/1", i, bus_err, dmem_we, dmem_req); end
            nxt;
        end
        #1;
        checks++; if (bus_err !== 1'b1 || dmem_we !== 1'b0 || reg_wr !== 1'b0) begin errors++; $display("FAIL sw_timeout got bus_err=%0b we=%0b reg_wr=%0b exp 1/0/0", bus_err, dmem_we, reg_wr); end
        nxt; #1;
        checks++; if (imem_req !== 1'b1 || bus_err !== 1'b0 || seen_wr != 0) begin errors++; $display("FAIL sw_ret got imem_req=%0b bus_err=%0b reg_wr_cycles=%0d exp 1/0/0", imem_req, bus_err, seen_wr); end
        $display("txn sw: bus timeout");
        // Ready arriving on the limit cycle wins over the timeout
        fetch_decode(6'b101011, 6'd0, 5'd0);
        nxt; dmem_ready = 1'b0;
        for (int i = 0; i < 15; i++) nxt;
        dmem_ready = 1'b1; #1;
        checks++; if (bus_err !== 1'b0 || dmem_we !== 1'b1) begin errors++; $display("FAIL sw_ready_wins got bus_err=%0b we=%0b exp 0/1", bus_err, dmem_we); end
        nxt; dmem_ready = 1'b0; #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sw_ready_ret got imem_req=%0b exp 1", imem_req); end
        $display("txn sw: ready on limit cycle");
        // Instruction fetch timeout, then counter restarts from zero
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) nxt;
        #1;
        checks++; if (bus_err !== 1'b1 || pc_wr !== 1'b0) begin errors++; $display("FAIL if_timeout got bus_err=%0b pc_wr=%0b exp 1/0", bus_err, pc_wr); end
        nxt; #1;
        checks++; if (bus_err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL if_restart got bus_err=%0b imem_req=%0b exp 0/1", bus_err, imem_req); end
        $display("txn fetch: bus timeout");
    endtask

    task automatic test_illegal_jumps;
        fetch_decode(6'b111111, 6'd0, 5'd0);
        // fetch_decode advanced through ID; step back by checking the ID cycle explicitly instead
        #1;
        checks++; if (imem_req !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL ill_ret got imem_req=%0b illegal=%0b exp 1/0", imem_req, illegal); end
        op = 6'b111111; imem_ready = 1'b1; #1; nxt; #1;
        checks++; if (illegal !== 1'b1 || reg_wr !== 1'b0 || dmem_we !== 1'b0 || pc_wr !== 1'b0) begin errors++; $display("FAIL ill_id got illegal=%0b reg_wr=%0b we=%0b pc_wr=%0b exp 1/0/0/0", illegal, reg_wr, dmem_we, pc_wr); end
        nxt;
        $display("txn illegal: op=111111");
        op = 6'b000000; func = 6'b001001; #1; nxt; #1;
        checks++; if (pc_wr !== 1'b1 || pc_src !== 2'd3) begin errors++; $display("FAIL jalr_id got pc_wr=%0b pc_src=%0d exp 1/3", pc_wr, pc_src); end
        nxt; #1;
        checks++; if (reg_wr !== 1'b1 || mem_to_reg !== 2'd2 || reg_dst !== 2'd1) begin errors++; $display("FAIL jalr_wb got reg_wr=%0b m2r=%0d reg_dst=%0d exp 1/2/1", reg_wr, mem_to_reg, reg_dst); end
        nxt;
        $display("txn jalr: link write");
        op = 6'b000010; func = 6'd0; #1; nxt; #1;
        checks++; if (pc_wr !== 1'b1 || pc_src !== 2'd2) begin errors++; $display("FAIL j_id got pc_wr=%0b pc_src=%0d exp 1/2", pc_wr, pc_src); end
        nxt; #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL j_ret got imem_req=%0b exp 1", imem_req); end
        $display("txn j: 2 cycles");
    endtask

    task automatic test_reset_mid;
        fetch_decode(6'b101011, 6'd0, 5'd0);
        nxt; dmem_ready = 1'b0; rst = 1'b1; #1;
        checks++; if (dmem_we !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL mid_rst got we=%0b req=%0b exp 0/0", dmem_we, dmem_req); end
        nxt; rst = 1'b0; imem_ready = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || dmem_we !== 1'b0 || reg_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_ret got imem_req=%0b we=%0b reg_wr=%0b exp 1/0/0", imem_req, dmem_we, reg_wr); end
        $display("txn sw: abandoned by reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addu();
        test_alu_table();
        test_load();
        test_branch();
        test_timeout();
        test_illegal_jumps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one register file and separate instruction/data memory ports.
- Each instruction passes through IF/ID/EX/MEM/WB states as its class requires.
- Memory accesses use a req/ready handshake, bounded by a wait-state timeout counter.
- Replaces the single-cycle control unit when the core runs against variable-latency memory.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for imem_ready/dmem_ready before bus_err.
- TO_W, 4, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- rt  in  5  IR[20:16]; selects bgez (00001) vs bltz (others) under op 000001
- zero  in  1  ALU branch-condition flag
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_wr  out  1  IR load enable
- pc_wr  out  1  PC write enable
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs
- alu_src  out  1  0 = rt, 1 = extended immediate
- ext_op  out  1  1 = sign-extend, 0 = zero-extend
- alu_op  out  5  ALU operation code
- shf_op  out  1  1 = shamt shift, 0 = rs shift
- dmem_req  out  1  data access request
- dmem_we  out  1  data write
- dm_op  out  1  1 = word, 0 = byte
- bit_op  out  1  byte load: 1 = sign-extend, 0 = zero-extend
- reg_wr  out  1  register file write
- reg_dst  out  2  0 = rt, 1 = rd
- mem_to_reg  out  2  0 = ALU, 1 = memory, 2 = PC+4
- illegal  out  1  one-cycle pulse on an undecodable instruction
- bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- States: S_IF, S_ID, S_EX, S_MEM, S_WB.
- Outputs are a combinational function of the state and the class register; every output is 0 while rst = 1.
- Reset:
  - The state enters S_IF on the edge where rst = 1.
  - The class register and timeout counter clear.
  - Reset asserted mid-instruction abandons the instruction; no reg_wr or dmem_we is issued afterwards.
- S_IF:
  - imem_req = 1 and ir_wr = 1.
  - When imem_ready = 1, also pc_wr = 1 with pc_src = 0, and the next state is S_ID.
- S_ID: decode op/func/rt and latch the class (RALU, SHIFT, JR, JALR, IALU, LOAD, STORE, BRANCH, J, ILL).
  - J: pc_wr = 1, pc_src = 2, next S_IF.
  - JR: pc_wr = 1, pc_src = 3, next S_IF.
  - JALR: pc_wr = 1, pc_src = 3, next S_WB.
  - ILL: illegal = 1, next S_IF.
  - All other classes: next S_EX.
- S_EX: drives alu_op, alu_src, ext_op and shf_op.
  - ALU codes:
    - Arithmetic/logic: add/addu/addi/addiu/lw/sw/lb/lbu/sb = 00000; sub/subu/beq = 00010; sltu/sltiu = 00100; slt/slti = 00101; and/andi = 00110; nor = 00111; or/ori = 01000; xor/xori = 01001.
    - Shifts: sll/sllv = 01010; lui = 01011; sra/srav = 01100; srl/srlv = 01110.
    - Branch conditions: bgez = 00001; bltz = 01111; bgtz = 00011; blez = 01101; bne = 11111.
  - Extension: ext_op = 0 for andi/ori/xori/lui; 1 otherwise.
  - BRANCH: pc_wr = zero, pc_src = 1, next S_IF.
  - LOAD/STORE: next S_MEM.
  - Other classes: next S_WB.
- S_MEM: dmem_req = 1, dmem_we = STORE, dm_op = (op is lw or sw), bit_op = (op == lb).
  - On dmem_ready = 1: LOAD goes to S_WB; STORE goes to S_IF.
  - dmem_we is never asserted outside S_MEM.
- S_WB: reg_wr = 1, then next S_IF.
  - reg_dst = 1 for RALU, SHIFT and JALR; 0 otherwise.
  - mem_to_reg = 1 for LOAD, 2 for JALR, 0 otherwise.
- Timeout:
  - The counter increments each cycle in S_IF or S_MEM while ready = 0, and clears on any state change.
  - If the counter equals MEM_TIMEOUT while ready = 0: bus_err = 1, next S_IF, and no pc_wr, reg_wr or dmem_we is issued.
  - If ready = 1 in the same cycle as the limit, ready wins.
- Latencies with zero wait states:
  - R/I ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - j/jr: 2 cycles.
  - jalr: 3 cycles.

Decomposition:
- Shared package mc_pkg:
  - State enum.
  - Class enum.
  - ALU_* opcode constants, reused by the ALU.
  - OP_* and FN_* opcode/func constants.
  - pc_src and mem_to_reg encodings.
- One sub-module, mc_decode: purely combinational mapping of op/func/rt to class and ALU/ext/shift fields, instantiated by mc_ctrl.

Test Plan:
- rst = 1 for 2 cycles with random inputs -> all outputs 0; on the first cycle after release, state is S_IF and imem_req = 1.
- addu (op 000000, func 100001), imem_ready held at 1 -> pc_wr in cycle 1, alu_op = 00000 in cycle 3, reg_wr = 1 with reg_dst = 1 in cycle 4, imem_req again in cycle 5.
- lw with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, then reg_wr = 1 with mem_to_reg = 1; dmem_we stays 0 throughout.
- beq with zero = 1, then zero = 0 -> pc_wr = 1 with pc_src = 1 in S_EX for the first; pc_wr = 0 for the second; both return to S_IF.
- sw with dmem_ready held at 0 -> bus_err pulses after 15 wait cycles, FSM returns to S_IF, and no reg_wr is issued.
- op 111111 -> illegal pulses in S_ID, no reg_wr or dmem_we; then jalr -> pc_src = 3, followed by reg_wr with mem_to_reg = 2.
